// File: rtl/led_pkg.sv
// led_pkg: shared LED types and default timing constants
package led_pkg;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} led_arb_state_t;
    localparam int LED_W            = 4;
    localparam int HOLD_CYCLES_DEF  = 25_000_000;
    localparam int GAP_CYCLES_DEF   = 2_500_000;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first set req bit above last
module rr_pick #(
    parameter int NREQ = 4,
    parameter int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic            any
);
    logic [LW-1:0] w_j;
    assign any = |req;
    // Walk offsets downward so the nearest candidate after last wins.
    always_comb begin
        win = '0;
        w_j = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_j = LW'((int'(last) + k) % NREQ);
            if (req[w_j]) win = NREQ'(1) << w_j;
        end
    end
endmodule

// File: rtl/led_arbiter.sv
// led_arbiter: round-robin owner of the LED bank with hold window and guard gap
module led_arbiter import led_pkg::*; #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [LED_W*NREQ-1:0] pat,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic                  busy,
    output logic [LED_W-1:0]      led
);
    localparam int LW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES);
    led_arb_state_t    r_state;
    logic [CW-1:0]     r_cnt;
    logic [LW-1:0]     r_last;
    logic [NREQ-1:0]   r_gnt;
    logic              r_done;
    logic              r_busy;
    logic [LED_W-1:0]  r_led;
    logic [NREQ-1:0]   w_win;
    logic              w_any;
    logic [LW-1:0]     w_idx;
    logic [LED_W-1:0]  w_pat;
    rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
        .req  (req),
        .last (r_last),
        .win  (w_win),
        .any  (w_any)
    );
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NREQ; i++) if (w_win[i]) w_idx = LW'(i);
    end
    assign w_pat = pat[LED_W*int'(w_idx) +: LED_W];
    // A completed window takes precedence over a req drop on its final cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= LW'(NREQ - 1);
            r_gnt   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_led   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_gnt   <= w_win;
                    r_led   <= w_pat;
                    r_last  <= w_idx;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= SHOW;
                end
                SHOW: if (r_cnt == CW'(HOLD_CYCLES - 1) || (req & r_gnt) == '0) begin
                    r_done  <= r_cnt == CW'(HOLD_CYCLES - 1);
                    r_gnt   <= '0;
                    r_led   <= '0;
                    r_cnt   <= '0;
                    r_state <= GAP;
                end else r_cnt <= r_cnt + 1'b1;
                GAP: if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end else r_cnt <= r_cnt + 1'b1;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;
    assign led  = r_led;
endmodule
